// File: rtl/ifu_fetch_fifo_if.sv
// IFU fetch-FIFO bus: fetch control, instruction-memory read port and IDU pop port.
// master = the fetch FIFO, slave = the surrounding fetch control / imem / IDU.
interface ifu_fetch_fifo_if #(
   parameter int FIFO_IFU_WIDTH = 64,
   parameter int ADDR_WIDTH     = 16,
   parameter int LEN_WIDTH      = 16
);
   logic                      fetch_start;
   logic [ADDR_WIDTH-1:0]     fetch_base_addr;
   logic [LEN_WIDTH-1:0]      fetch_len;
   logic                      imem_rd_en;
   logic [ADDR_WIDTH-1:0]     imem_addr;
   logic [FIFO_IFU_WIDTH-1:0] imem_rd_data;
   logic                      idu2ifu_rd_rqst;
   logic                      ifu2idu_fifo_empty;
   logic [FIFO_IFU_WIDTH-1:0] ifu2idu_rd_data;
   logic                      ifu2idu_rd_data_vld;
   logic                      fetch_busy;
   logic                      fetch_done;
   logic                      fifo_underflow;

   modport master (
      input  fetch_start, fetch_base_addr, fetch_len, imem_rd_data, idu2ifu_rd_rqst,
      output imem_rd_en, imem_addr, ifu2idu_fifo_empty, ifu2idu_rd_data,
             ifu2idu_rd_data_vld, fetch_busy, fetch_done, fifo_underflow
   );

   modport slave (
      output fetch_start, fetch_base_addr, fetch_len, imem_rd_data, idu2ifu_rd_rqst,
      input  imem_rd_en, imem_addr, ifu2idu_fifo_empty, ifu2idu_rd_data,
             ifu2idu_rd_data_vld, fetch_busy, fetch_done, fifo_underflow
   );
endinterface

// File: rtl/ifu_fetch_fifo.sv
// Streams a programmed run of instruction words from imem into a circular FIFO
// and serves IDU pops with read data one cycle after each accepted request.
module ifu_fetch_fifo #(
   parameter int FIFO_IFU_WIDTH = 64,
   parameter int DEPTH          = 16,
   parameter int ADDR_WIDTH     = 16,
   parameter int LEN_WIDTH      = 16
) (
   input  logic             clk,
   input  logic             rst,
   ifu_fetch_fifo_if.master bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW:0] DEPTH_OCC = (CW+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic [LEN_WIDTH-1:0]  remain;
   } run_t;

   state_t                    state_q, state_d;
   run_t                      run_q, run_d;
   logic                      issue, start_acc;
   logic                      inflight_q;
   logic                      busy_q, busy_d, done_q, underflow_q;

   logic [FIFO_IFU_WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]             wptr_q, rptr_q;
   logic [CW-1:0]             count_q;
   logic [CW:0]               occ;
   logic                      push, pop, fifo_empty;
   logic [FIFO_IFU_WIDTH-1:0] rd_data_q;
   logic                      rd_vld_q;

   assign fifo_empty = (count_q == '0);
   assign push       = inflight_q;
   assign pop        = bus.idu2ifu_rd_rqst && !fifo_empty;
   // Slots already promised to an in-flight read count as used; pops are not credited.
   assign occ        = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};

   always_comb begin
      state_d   = state_q;
      run_d     = run_q;
      issue     = 1'b0;
      start_acc = 1'b0;
      busy_d    = busy_q;
      case (state_q)
         IDLE: begin
            if (bus.fetch_start) begin
               start_acc  = 1'b1;
               busy_d     = 1'b1;
               run_d.addr   = bus.fetch_base_addr;
               run_d.remain = bus.fetch_len;
               state_d    = (bus.fetch_len == '0) ? DONE : FETCH;
            end
         end
         FETCH: begin
            if (run_q.remain != '0 && occ < DEPTH_OCC) begin
               issue        = 1'b1;
               run_d.addr   = run_q.addr + ADDR_WIDTH'(1);
               run_d.remain = run_q.remain - LEN_WIDTH'(1);
               if (run_q.remain == LEN_WIDTH'(1)) state_d = DRAIN;
            end
         end
         DRAIN: state_d = DONE;
         DONE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         run_q       <= '0;
         inflight_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         run_q      <= run_d;
         inflight_q <= issue;
         busy_q     <= busy_d;
         done_q     <= (state_q == DONE);
         if (bus.idu2ifu_rd_rqst && fifo_empty) underflow_q <= 1'b1;
         else if (start_acc)                    underflow_q <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q    <= '0;
         rptr_q    <= '0;
         count_q   <= '0;
         rd_data_q <= '0;
         rd_vld_q  <= 1'b0;
      end else begin
         rd_vld_q <= pop;
         if (push) wptr_q <= wptr_q + PW'(1);
         if (pop) begin
            rptr_q    <= rptr_q + PW'(1);
            rd_data_q <= mem[rptr_q];
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage needs no reset; only pointer/count state defines what is valid.
   always_ff @(posedge clk) begin
      if (push) mem[wptr_q] <= bus.imem_rd_data;
   end

   assign bus.imem_rd_en          = issue;
   assign bus.imem_addr           = run_q.addr;
   assign bus.ifu2idu_fifo_empty  = fifo_empty;
   assign bus.ifu2idu_rd_data     = rd_data_q;
   assign bus.ifu2idu_rd_data_vld = rd_vld_q;
   assign bus.fetch_busy          = busy_q;
   assign bus.fetch_done          = done_q;
   assign bus.fifo_underflow      = underflow_q;
endmodule

// File: tb/tb_ifu_fetch_fifo.sv
// Directed bench for ifu_fetch_fifo: imem model, scoreboard of expected pops, event monitors.
module tb_ifu_fetch_fifo;
   localparam int W = 64, DEPTH = 16, AW = 16, LW = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ifu_fetch_fifo_if #(.FIFO_IFU_WIDTH(W), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

   ifu_fetch_fifo #(.FIFO_IFU_WIDTH(W), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   int tests = 0, fails = 0;
   int cyc = 0;
   logic [W-1:0]  exp_q[$];
   logic [AW-1:0] addr_log[$];
   int            rd_cyc_log[$];
   int            vld_log[$];
   int            rd_cnt = 0, vld_cnt = 0, done_cnt = 0, done_cyc = 0;

   function automatic logic [W-1:0] mem_word(logic [AW-1:0] a);
      return W'(a) + 64'h100;
   endfunction

   task automatic check(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // imem returns data exactly one cycle after the strobe, junk otherwise
   always @(posedge clk) begin
      if (bus.imem_rd_en) bus.imem_rd_data <= mem_word(bus.imem_addr);
      else                bus.imem_rd_data <= 64'hDEAD_BEEF_0BAD_F00D;
   end

   always @(negedge clk) begin
      if (bus.imem_rd_en) begin
         rd_cnt++;
         addr_log.push_back(bus.imem_addr);
         rd_cyc_log.push_back(cyc);
      end
      if (bus.fetch_done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (bus.ifu2idu_rd_data_vld) begin
         vld_cnt++;
         vld_log.push_back(cyc);
         check("sb_has_entry", W'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) check("rd_data", bus.ifu2idu_rd_data, exp_q.pop_front());
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input logic [AW-1:0] b, input logic [LW-1:0] l, output int sc);
      bus.fetch_base_addr = b;
      bus.fetch_len       = l;
      bus.fetch_start     = 1'b1;
      for (int i = 0; i < int'(l); i++) exp_q.push_back(mem_word(b + AW'(i)));
      sc = cyc;
      step();
      bus.fetch_start = 1'b0;
   endtask

   task automatic wait_done(input int d0, input int bound);
      int n = 0;
      while (done_cnt == d0 && n < bound) begin
         step();
         n++;
      end
      check("done_seen", W'(done_cnt != d0), 64'd1);
   endtask

   // pop only while the FIFO reports data, so no underflow is provoked
   task automatic drain(input int n, input int bound);
      int v0 = vld_cnt;
      int k = 0;
      while ((vld_cnt - v0) < n && k < bound) begin
         bus.idu2ifu_rd_rqst = !bus.ifu2idu_fifo_empty;
         step();
         k++;
      end
      bus.idu2ifu_rd_rqst = 1'b0;
      check("drain_cnt", W'(vld_cnt - v0), W'(n));
   endtask

   task automatic check_reset_outputs(string pfx);
      check({pfx, "_empty"},     W'(bus.ifu2idu_fifo_empty),  64'd1);
      check({pfx, "_vld"},       W'(bus.ifu2idu_rd_data_vld), 64'd0);
      check({pfx, "_rd_data"},   bus.ifu2idu_rd_data,         64'd0);
      check({pfx, "_rd_en"},     W'(bus.imem_rd_en),          64'd0);
      check({pfx, "_imem_addr"}, W'(bus.imem_addr),           64'd0);
      check({pfx, "_busy"},      W'(bus.fetch_busy),          64'd0);
      check({pfx, "_done"},      W'(bus.fetch_done),          64'd0);
      check({pfx, "_underflow"}, W'(bus.fifo_underflow),      64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
      $fatal(1, "watchdog");
   end

   initial begin
      int r0, a0, d0, v0, vl0, sc, k;
      bus.fetch_start     = 1'b0;
      bus.fetch_base_addr = '0;
      bus.fetch_len       = '0;
      bus.idu2ifu_rd_rqst = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("rst");
      rst = 1'b0;
      step();

      // three-word run, no requests
      r0 = rd_cnt; a0 = addr_log.size(); d0 = done_cnt;
      start(16'h0010, 16'd3, sc);
      check("busy_after_start", W'(bus.fetch_busy), 64'd1);
      wait_done(d0, 50);
      repeat (3) step();
      check("t1_done_once", W'(done_cnt - d0), 64'd1);
      check("t1_reads", W'(rd_cnt - r0), 64'd3);
      check("t1_addr0", W'(addr_log[a0]),   64'h10);
      check("t1_addr1", W'(addr_log[a0+1]), 64'h11);
      check("t1_addr2", W'(addr_log[a0+2]), 64'h12);
      check("t1_consecutive", W'(rd_cyc_log[a0+2] - rd_cyc_log[a0]), 64'd2);
      check("t1_not_empty", W'(bus.ifu2idu_fifo_empty), 64'd0);
      check("t1_busy_clear", W'(bus.fetch_busy), 64'd0);

      // three back-to-back pops
      v0 = vld_cnt;
      bus.idu2ifu_rd_rqst = 1'b1;
      repeat (3) step();
      bus.idu2ifu_rd_rqst = 1'b0;
      check("t2_empty", W'(bus.ifu2idu_fifo_empty), 64'd1);
      repeat (2) step();
      check("t2_vld_cnt", W'(vld_cnt - v0), 64'd3);
      check("t2_sb_drained", W'(exp_q.size()), 64'd0);
      check("t2_data_hold", bus.ifu2idu_rd_data, 64'h112);
      check("t2_underflow", W'(bus.fifo_underflow), 64'd0);

      // len=20 stalls after DEPTH reads, one pop frees exactly one slot
      r0 = rd_cnt; d0 = done_cnt;
      start(16'h0000, 16'd20, sc);
      repeat (40) step();
      check("t3_stall_reads", W'(rd_cnt - r0), 64'd16);
      check("t3_stall_rd_en", W'(bus.imem_rd_en), 64'd0);
      check("t3_busy", W'(bus.fetch_busy), 64'd1);
      bus.idu2ifu_rd_rqst = 1'b1;
      step();
      bus.idu2ifu_rd_rqst = 1'b0;
      repeat (10) step();
      check("t3_one_more", W'(rd_cnt - r0), 64'd17);
      drain(19, 300);
      wait_done(d0, 50);
      check("t3_sb_drained", W'(exp_q.size()), 64'd0);

      // len=40 with continuous requests
      r0 = rd_cnt; d0 = done_cnt; v0 = vld_cnt; vl0 = vld_log.size(); a0 = rd_cyc_log.size();
      start(16'h1000, 16'd40, sc);
      bus.idu2ifu_rd_rqst = 1'b1;
      k = 0;
      while ((vld_cnt - v0) < 40 && k < 300) begin
         step();
         k++;
      end
      bus.idu2ifu_rd_rqst = 1'b0;
      check("t4_vld_cnt", W'(vld_cnt - v0), 64'd40);
      if (vld_log.size() >= vl0 + 40)
         check("t4_no_gaps", W'(vld_log[vl0+39] - vld_log[vl0]), 64'd39);
      check("t4_reads", W'(rd_cnt - r0), 64'd40);
      wait_done(d0, 50);
      check("t4_done_once", W'(done_cnt - d0), 64'd1);
      if (rd_cyc_log.size() >= a0 + 40)
         check("t4_done_after_last_write", W'(done_cyc - rd_cyc_log[a0+39]), 64'd3);

      // underflow is sticky until the next fetch_start
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      check("t5_uf_reset", W'(bus.fifo_underflow), 64'd0);
      v0 = vld_cnt;
      bus.idu2ifu_rd_rqst = 1'b1;
      step();
      bus.idu2ifu_rd_rqst = 1'b0;
      repeat (3) step();
      check("t5_no_vld", W'(vld_cnt - v0), 64'd0);
      check("t5_uf_set", W'(bus.fifo_underflow), 64'd1);
      repeat (5) step();
      check("t5_uf_sticky", W'(bus.fifo_underflow), 64'd1);
      d0 = done_cnt;
      start(16'h0200, 16'd1, sc);
      check("t5_uf_cleared", W'(bus.fifo_underflow), 64'd0);
      drain(1, 50);
      wait_done(d0, 50);

      // reset in the middle of a run
      r0 = rd_cnt;
      start(16'h0300, 16'd20, sc);
      k = 0;
      while ((rd_cnt - r0) < 5 && k < 50) begin
         step();
         k++;
      end
      check("t6_five_reads", W'((rd_cnt - r0) >= 5), 64'd1);
      rst = 1'b1;
      #1;
      check_reset_outputs("midrst");
      exp_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      step();
      v0 = vld_cnt; d0 = done_cnt;
      start(16'h0400, 16'd2, sc);
      drain(2, 50);
      wait_done(d0, 50);
      repeat (5) step();
      check("t6_only_two", W'(vld_cnt - v0), 64'd2);
      check("t6_sb_drained", W'(exp_q.size()), 64'd0);

      // zero-length run
      r0 = rd_cnt; d0 = done_cnt;
      start(16'h0500, 16'd0, sc);
      wait_done(d0, 10);
      check("t7_done_latency", W'(done_cyc - sc), 64'd2);
      check("t7_no_reads", W'(rd_cnt - r0), 64'd0);
      repeat (3) step();
      check("t7_done_once", W'(done_cnt - d0), 64'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/ifu_fetch_fifo.md
Name: ifu_fetch_fifo

Overview:
- Instruction-fetch-side responder for the IDU read interface.
- Streams a programmed run of 64-bit instruction words from instruction memory into an internal FIFO.
- Serves IDU read requests one word at a time, with data valid one cycle after each accepted request.
- Sits between instruction memory and the IDU control unit; owns `ifu2idu_fifo_empty`, `ifu2idu_rd_data` and `ifu2idu_rd_data_vld`.

Parameters:
- FIFO_IFU_WIDTH, 64, instruction word width
- DEPTH, 16, FIFO entries (power of two, >=4)
- ADDR_WIDTH, 16, instruction memory word-address width
- LEN_WIDTH, 16, width of fetch length in words

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- fetch_start  in  1  one-cycle pulse; starts a fetch run
- fetch_base_addr  in  ADDR_WIDTH  first word address, sampled with fetch_start
- fetch_len  in  LEN_WIDTH  number of words to fetch, sampled with fetch_start
- imem_rd_en  out  1  instruction memory read strobe
- imem_addr  out  ADDR_WIDTH  instruction memory word address
- imem_rd_data  in  FIFO_IFU_WIDTH  memory data, valid exactly 1 cycle after imem_rd_en
- idu2ifu_rd_rqst  in  1  IDU pop request, level-sampled every cycle
- ifu2idu_fifo_empty  out  1  FIFO holds no words
- ifu2idu_rd_data  out  FIFO_IFU_WIDTH  popped word
- ifu2idu_rd_data_vld  out  1  ifu2idu_rd_data valid this cycle
- fetch_busy  out  1  fetch run in progress
- fetch_done  out  1  one-cycle pulse; last word of run written into FIFO
- fifo_underflow  out  1  sticky; request seen while empty

Behaviour:
- Reset (asynchronous, active-high, any time including mid-run):
  - FIFO pointers and count = 0; in-flight memory read discarded.
  - FSM = IDLE.
  - imem_rd_en=0, imem_addr=0, ifu2idu_rd_data=0, ifu2idu_rd_data_vld=0, fetch_busy=0, fetch_done=0, fifo_underflow=0.
  - ifu2idu_fifo_empty=1.
- FIFO:
  - count range 0..DEPTH; circular buffer, pointers wrap modulo DEPTH.
  - ifu2idu_fifo_empty = (count==0), decoded from registered count only; no combinational path from inputs.
- Pop:
  - Condition: idu2ifu_rd_rqst=1 and count>0 in cycle N.
  - Cycle N+1: ifu2idu_rd_data = word at read pointer, ifu2idu_rd_data_vld=1.
  - Read pointer advances at end of cycle N.
  - Back-to-back requests pop one word per cycle.
  - ifu2idu_rd_data holds its last value when vld=0.
- Request while count==0: ignored, vld=0 next cycle, fifo_underflow set (cleared only by reset or fetch_start).
- Push: when imem_rd_data is valid (cycle after imem_rd_en), the word is written at the write pointer.
- Simultaneous push and pop: count unchanged. Pop uses pre-push contents, so a word written in cycle N is not poppable until cycle N+1.
- FSM states:
  - IDLE: fetch_start -> capture addr/len, clear fifo_underflow, fetch_busy=1. len==0 -> DONE; else -> FETCH. fetch_start is ignored in every other state.
  - FETCH:
    - Issue a read (imem_rd_en=1, imem_addr=current addr) when remaining>0 and count + inflight < DEPTH, where inflight = imem_rd_en of the previous cycle. Pops are not credited.
    - On issue: addr+1 (wraps at 2^ADDR_WIDTH), remaining-1.
    - remaining reaches 0 on issue -> DRAIN.
  - DRAIN: wait one cycle for the final in-flight word to be written -> DONE.
  - DONE: fetch_done=1 for one cycle, fetch_busy=0 -> IDLE.
- No overflow by construction: push never occurs with count==DEPTH and no pop.
- FIFO contents persist across runs; a new run appends behind unconsumed words.

Test Plan:
- rst, fetch_start base=0x0010 len=3, mem[a]=a+0x100, no requests -> imem_addr 0x10,0x11,0x12 on consecutive cycles; count=3; fetch_done pulses once; empty=0.
- Then idu2ifu_rd_rqst held 3 cycles -> vld high 3 cycles with data 0x110,0x111,0x112; empty=1 after the third pop; fifo_underflow=0.
- len=20, DEPTH=16, no requests -> exactly 16 reads issued, rd_en stalls. Pop one -> exactly one more read issued. Final data order 0..19 intact.
- Continuous requests during a len=40 run -> 40 words delivered in order, no gaps once the FIFO is non-empty, fetch_done after the 40th write.
- Request with FIFO empty after reset -> vld stays 0, fifo_underflow=1 and stays 1. Next fetch_start -> fifo_underflow=0.
- Assert rst mid-run after 5 reads -> all outputs return to reset values immediately. New fetch_start len=2 -> only 2 words delivered, none from the aborted run. len=0 -> fetch_done on the second cycle after fetch_start, no imem_rd_en.
